// File: rtl/ex_hilo_pkg.sv
// ex_hilo_pkg: shared definitions for the execute stage.
//   - aluop codes decoded by ex_hilo
//   - multiplier iteration count and FSM state encoding
//   - small helpers: 32-bit magnitude and "is a multiply" decode
`timescale 1ns/1ps
package ex_hilo_pkg;

    localparam int MUL_CYCLES = 32;

    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_SLL   = 8'h7C;
    localparam logic [7:0] OP_SRL   = 8'h02;
    localparam logic [7:0] OP_SRA   = 8'h03;
    localparam logic [7:0] OP_MOVZ  = 8'h0A;
    localparam logic [7:0] OP_MOVN  = 8'h0B;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Two's-complement magnitude. 0x80000000 maps to itself, which read
    // as unsigned is exactly 2^31, so no extra bit is needed.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic is_mult_op(input logic [7:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/ex_hilo_if.sv
// ex_hilo_if: decode -> execute bundle plus the execute results that go
// to EX/MEM and back to decode's forwarding inputs.
//   master: decode side (drives aluop/operands/destination)
//   slave : ex_hilo (drives wdata_o, wd_o, wreg_o, stall_req_o)
`timescale 1ns/1ps
interface ex_hilo_if;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        wreg_i;
    logic [4:0]  wd_i;
    logic [31:0] wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic        stall_req_o;

    modport master (
        output aluop_i, reg1_i, reg2_i, wreg_i, wd_i,
        input  wdata_o, wd_o, wreg_o, stall_req_o
    );

    modport slave (
        input  aluop_i, reg1_i, reg2_i, wreg_i, wd_i,
        output wdata_o, wd_o, wreg_o, stall_req_o
    );
endinterface

// File: rtl/ex_hilo_mul_iter.sv
// mul_iter: iterative shift-add 32x32 multiplier, one multiplier bit per
// cycle. Signed operation multiplies magnitudes and negates at the end.
//   clk, rst : clock, asynchronous active-high reset
//   start    : multiply requested (only acted on while IDLE)
//   sgn      : 1 = signed (mult), 0 = unsigned (multu)
//   a, b     : operands, must stay stable while busy
//   busy     : pipeline must be held (start cycle and all BUSY cycles)
//   done     : product valid this cycle (DONE state)
//   product  : 64-bit signed-corrected result
`timescale 1ns/1ps
module mul_iter
    import ex_hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    mul_state_e  state_reg, state_next;
    logic [4:0]  count_reg;
    logic [63:0] acc_reg;
    logic [63:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic        neg_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (count_reg == 5'(MUL_CYCLES - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            neg_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        count_reg  <= '0;
                        acc_reg    <= '0;
                        mcand_reg  <= {32'd0, sgn ? abs32(a) : a};
                        mplier_reg <= sgn ? abs32(b) : b;
                        neg_reg    <= sgn & (a[31] ^ b[31]);
                    end
                end
                BUSY: begin
                    if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = ((state_reg == IDLE) && start) || (state_reg == BUSY);
    assign done    = (state_reg == DONE);
    assign product = neg_reg ? (~acc_reg + 64'd1) : acc_reg;

endmodule

// File: rtl/ex_hilo.sv
// ex_hilo: MIPS32 execute stage with logic/shift/move ops, the HI/LO pair
// and an iterative multiplier that stalls the front of the pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   ex       : slave side of ex_hilo_if (aluop/operands/destination in,
//              wdata_o/wd_o/wreg_o/stall_req_o out, all combinational)
`timescale 1ns/1ps
module ex_hilo
    import ex_hilo_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ex_hilo_if.slave ex
);

    logic [31:0] hi_reg, lo_reg;
    logic        is_mult;
    logic        mul_busy, mul_done;
    logic [63:0] mul_product;
    logic        stall;
    logic [31:0] wdata;
    logic        wreg;

    assign is_mult = is_mult_op(ex.aluop_i);

    mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (is_mult),
        .sgn     (ex.aluop_i == OP_MULT),
        .a       (ex.reg1_i),
        .b       (ex.reg2_i),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // The start-cycle term of busy is combinational from aluop, so it must
    // be masked while reset holds the engine idle.
    assign stall = ~rst & mul_busy;

    // HI/LO: the multiply result wins over mthi/mtlo, although the pipeline
    // being held behind the multiply means they cannot normally meet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (mul_done) begin
            {hi_reg, lo_reg} <= mul_product;
        end else if (!stall) begin
            if (ex.aluop_i == OP_MTHI) hi_reg <= ex.reg1_i;
            if (ex.aluop_i == OP_MTLO) lo_reg <= ex.reg1_i;
        end
    end

    always_comb begin
        wdata = '0;
        wreg  = 1'b0;
        case (ex.aluop_i)
            OP_AND:  begin wdata = ex.reg1_i & ex.reg2_i;    wreg = ex.wreg_i; end
            OP_OR:   begin wdata = ex.reg1_i | ex.reg2_i;    wreg = ex.wreg_i; end
            OP_XOR:  begin wdata = ex.reg1_i ^ ex.reg2_i;    wreg = ex.wreg_i; end
            OP_NOR:  begin wdata = ~(ex.reg1_i | ex.reg2_i); wreg = ex.wreg_i; end
            OP_SLL:  begin wdata = ex.reg2_i << ex.reg1_i[4:0]; wreg = ex.wreg_i; end
            OP_SRL:  begin wdata = ex.reg2_i >> ex.reg1_i[4:0]; wreg = ex.wreg_i; end
            OP_SRA:  begin
                wdata = 32'($signed(ex.reg2_i) >>> ex.reg1_i[4:0]);
                wreg  = ex.wreg_i;
            end
            OP_MOVZ: begin wdata = ex.reg1_i; wreg = ex.wreg_i & (ex.reg2_i == 32'd0); end
            OP_MOVN: begin wdata = ex.reg1_i; wreg = ex.wreg_i & (ex.reg2_i != 32'd0); end
            OP_MFHI: begin wdata = hi_reg; wreg = ex.wreg_i; end
            OP_MFLO: begin wdata = lo_reg; wreg = ex.wreg_i; end
            default: ;  // mthi/mtlo/mult/multu/bubble/unknown: no GPR write
        endcase
    end

    assign ex.wdata_o     = rst ? 32'd0 : wdata;
    assign ex.wreg_o      = rst ? 1'b0  : wreg;
    assign ex.wd_o        = rst ? 5'd0  : ex.wd_i;
    assign ex.stall_req_o = stall;

endmodule

// File: tb/tb_ex_hilo.sv
// tb_ex_hilo: directed and randomized checks of ex_hilo against an
// operation-level reference model (plain arithmetic, 64-bit products,
// multiply occupancy tracked as a cycle count).
`timescale 1ns/1ps
module tb_ex_hilo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_hilo_if ifc();

    ex_hilo dut (
        .clk (clk),
        .rst (rst),
        .ex  (ifc)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_prod = '0;
    int          m_phase = 0;   // 0: no multiply; 1..33: cycles into one

    always @(negedge clk) begin
        logic [7:0]  op;
        logic [31:0] a, b, e_data;
        logic        w, e_wreg, e_stall;
        int          sh;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_phase = 0;
            chk("rst_wdata", ifc.wdata_o, 0);
            chk("rst_wd",    ifc.wd_o, 0);
            chk("rst_wreg",  ifc.wreg_o, 0);
            chk("rst_stall", ifc.stall_req_o, 0);
        end else begin
            op = ifc.aluop_i; a = ifc.reg1_i; b = ifc.reg2_i; w = ifc.wreg_i;
            e_data = '0; e_wreg = 1'b0; e_stall = 1'b0;
            sh = int'(a[4:0]);
            if (m_phase > 0) begin
                // 32 iterations after the start cycle, then one result cycle
                e_stall = (m_phase <= 32);
                if (m_phase == 33) begin
                    {m_hi, m_lo} = m_prod;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
            end else if (op == 8'h18 || op == 8'h19) begin
                e_stall = 1'b1;
                if (op == 8'h18) m_prod = 64'(longint'($signed(a)) * longint'($signed(b)));
                else             m_prod = {32'd0, a} * {32'd0, b};
                m_phase = 1;
            end else begin
                case (op)
                    8'h24: begin e_data = a & b;    e_wreg = w; end
                    8'h25: begin e_data = a | b;    e_wreg = w; end
                    8'h26: begin e_data = a ^ b;    e_wreg = w; end
                    8'h27: begin e_data = ~(a | b); e_wreg = w; end
                    8'h7C: begin e_data = b << sh;  e_wreg = w; end
                    8'h02: begin e_data = b >> sh;  e_wreg = w; end
                    8'h03: begin
                        e_data = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                        e_wreg = w;
                    end
                    8'h0A: begin e_data = a; e_wreg = w && (b == 0); end
                    8'h0B: begin e_data = a; e_wreg = w && (b != 0); end
                    8'h10: begin e_data = m_hi; e_wreg = w; end
                    8'h12: begin e_data = m_lo; e_wreg = w; end
                    8'h11: m_hi = a;
                    8'h13: m_lo = a;
                    default: ;
                endcase
            end
            chk("wdata", ifc.wdata_o, e_data);
            chk("wreg",  ifc.wreg_o, e_wreg);
            chk("wd",    ifc.wd_o, ifc.wd_i);
            chk("stall", ifc.stall_req_o, e_stall);
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; holds the instruction while the stage stalls and
    // returns at posedge+1 after the edge that retires it.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic w, input logic [4:0] d,
                         output logic [31:0] rd, output logic rw, output logic [4:0] rwd,
                         output int stalls);
        ifc.aluop_i = op; ifc.reg1_i = a; ifc.reg2_i = b; ifc.wreg_i = w; ifc.wd_i = d;
        stalls = 0;
        @(negedge clk);
        rd = ifc.wdata_o; rw = ifc.wreg_o; rwd = ifc.wd_o;
        while (ifc.stall_req_o === 1'b1) begin
            stalls++;
            if (stalls > 100) begin
                total++; bad++;
                $display("FAIL stall_timeout: stalled %0d cycles, required at most 33", stalls);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        $display("op=%02h a=%08h b=%08h wd=%0d -> wdata=%08h wreg=%0d stalls=%0d",
                 op, a, b, d, rd, rw, stalls);
    endtask

    logic [7:0] ops [15] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h0A,
                             8'h0B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h18, 8'h19};

    initial begin
        logic [31:0] rd, ra, rb;
        logic        rw;
        logic [4:0]  rwd;
        logic [7:0]  rop;
        int          st;

        ifc.aluop_i = 8'h25; ifc.reg1_i = 32'hFFFF_0000; ifc.reg2_i = 32'h0000_FFFF;
        ifc.wreg_i = 1'b1; ifc.wd_i = 5'd7;
        @(negedge clk);
        chk("reset_wdata", ifc.wdata_o, 0);
        chk("reset_wreg",  ifc.wreg_o, 0);
        chk("reset_wd",    ifc.wd_o, 0);
        chk("reset_stall", ifc.stall_req_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(8'h25, 32'h0000_FF00, 32'h00FF_00FF, 1'b1, 5'd3, rd, rw, rwd, st);
        chk("or_data", rd, 32'h00FF_FFFF); chk("or_wreg", rw, 1); chk("or_wd", rwd, 3);
        issue(8'h03, 32'd4, 32'h8000_0000, 1'b1, 5'd4, rd, rw, rwd, st);
        chk("sra_data", rd, 32'hF800_0000);
        issue(8'h02, 32'd4, 32'h8000_0000, 1'b1, 5'd4, rd, rw, rwd, st);
        chk("srl_data", rd, 32'h0800_0000);
        issue(8'h0B, 32'h1234, 32'd0, 1'b1, 5'd5, rd, rw, rwd, st);
        chk("movn_zero_wreg", rw, 0);
        issue(8'h0B, 32'h1234, 32'd5, 1'b1, 5'd5, rd, rw, rwd, st);
        chk("movn_nz_wreg", rw, 1); chk("movn_nz_data", rd, 32'h1234);
        issue(8'h0A, 32'h1234, 32'd0, 1'b1, 5'd6, rd, rw, rwd, st);
        chk("movz_zero_wreg", rw, 1); chk("movz_zero_data", rd, 32'h1234);
        issue(8'h0A, 32'h1234, 32'd5, 1'b1, 5'd6, rd, rw, rwd, st);
        chk("movz_nz_wreg", rw, 0);

        issue(8'h18, 32'h8000_0000, 32'h8000_0000, 1'b0, 5'd0, rd, rw, rwd, st);
        chk("mult_min_stalls", st, 33);
        issue(8'h10, 32'd0, 32'd0, 1'b1, 5'd8, rd, rw, rwd, st);
        chk("mult_min_hi", rd, 32'h4000_0000);
        issue(8'h12, 32'd0, 32'd0, 1'b1, 5'd8, rd, rw, rwd, st);
        chk("mult_min_lo", rd, 32'h0);
        issue(8'h18, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, rd, rw, rwd, st);
        issue(8'h10, 32'd0, 32'd0, 1'b1, 5'd8, rd, rw, rwd, st);
        chk("mult_neg1_hi", rd, 32'hFFFF_FFFF);
        issue(8'h12, 32'd0, 32'd0, 1'b1, 5'd8, rd, rw, rwd, st);
        chk("mult_neg1_lo", rd, 32'hFFFF_FFFF);
        issue(8'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0, rd, rw, rwd, st);
        issue(8'h10, 32'd0, 32'd0, 1'b1, 5'd8, rd, rw, rwd, st);
        chk("multu_max_hi", rd, 32'hFFFF_FFFE);
        issue(8'h12, 32'd0, 32'd0, 1'b1, 5'd8, rd, rw, rwd, st);
        chk("multu_max_lo", rd, 32'h0000_0001);
        issue(8'h11, 32'hAAAA_5555, 32'd0, 1'b0, 5'd0, rd, rw, rwd, st);
        issue(8'h10, 32'd0, 32'd0, 1'b1, 5'd9, rd, rw, rwd, st);
        chk("mthi_mfhi", rd, 32'hAAAA_5555);

        for (int i = 0; i < 200; i++) begin
            rop = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ops[$urandom_range(0, 14)];
            ra  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            issue(rop, ra, rb, 1'($urandom), 5'($urandom), rd, rw, rwd, st);
        end

        // Abort a multiply mid-flight with reset.
        issue(8'h13, 32'h1357_9BDF, 32'd0, 1'b0, 5'd0, rd, rw, rwd, st);
        issue(8'h11, 32'h2468_ACE0, 32'd0, 1'b0, 5'd0, rd, rw, rwd, st);
        ifc.aluop_i = 8'h18; ifc.reg1_i = 32'd123; ifc.reg2_i = 32'd456; ifc.wreg_i = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("abort_stall_drop", ifc.stall_req_o, 0);
        ifc.aluop_i = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(8'h10, 32'd0, 32'd0, 1'b1, 5'd1, rd, rw, rwd, st);
        chk("abort_hi", rd, 32'h0);
        issue(8'h12, 32'd0, 32'd0, 1'b1, 5'd1, rd, rw, rwd, st);
        chk("abort_lo", rd, 32'h0);
        issue(8'h18, 32'd7, 32'hFFFF_FFFA, 1'b0, 5'd0, rd, rw, rwd, st);
        chk("rerun_stalls", st, 33);
        issue(8'h12, 32'd0, 32'd0, 1'b1, 5'd1, rd, rw, rwd, st);
        chk("rerun_lo", rd, 32'hFFFF_FFD6);
        issue(8'h10, 32'd0, 32'd0, 1'b1, 5'd1, rd, rw, rwd, st);
        chk("rerun_hi", rd, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_hilo.md
# ex_hilo

Execute stage of the five-stage MIPS32 pipeline, directly downstream of the decode stage. It consumes decoded `aluop`/operands/destination, performs logic, shift, conditional-move and HI/LO operations, and returns its result combinationally to the EX/MEM register and to decode's `ex_*` forwarding inputs. It owns the architectural HI/LO pair and an iterative 32x32 multiplier that stalls the front of the pipeline while it runs.

## Interface
- `MUL_CYCLES`, 32: multiplier iterations, one bit per cycle; fixed at 32.
- `clk`  in  1  pipeline clock
- `rst`  in  1  reset; asynchronous, active-high
- `aluop_i`  in  8  operation code from decode (codes under Operation)
- `reg1_i`  in  32  operand 1; carries shamt for immediate shifts
- `reg2_i`  in  32  operand 2
- `wreg_i`  in  1  decode's GPR write enable
- `wd_i`  in  5  destination GPR
- `wdata_o`  out  32  result to EX/MEM and decode `ex_wdata_i`
- `wd_o`  out  5  destination to EX/MEM and decode `ex_wd_i`
- `wreg_o`  out  1  final GPR write enable to EX/MEM and decode `ex_wreg_i`
- `stall_req_o`  out  1  hold PC, IF/ID and ID/EX; inputs must stay stable while high

## Operation
- aluop codes: and 0x24, or 0x25, xor 0x26, nor 0x27, sll 0x7C, srl 0x02, sra 0x03, movz 0x0A, movn 0x0B, mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13, mult 0x18, multu 0x19.
- `wd_o` = `wd_i` always. Any other code, including 0x00 (bubble): `wdata_o`=0, `wreg_o`=0.
- Logic ops: bitwise on `reg1_i`,`reg2_i`; `wreg_o`=`wreg_i`.
- Shifts: value `reg2_i`, amount `reg1_i[4:0]`; sra sign-fills; `wreg_o`=`wreg_i`.
- movn: `wdata_o`=`reg1_i`, `wreg_o`=`wreg_i` & (`reg2_i`!=0). movz: same with (`reg2_i`==0).
- mfhi/mflo: `wdata_o`=HI/LO, `wreg_o`=`wreg_i`.
- mthi/mtlo: `wreg_o`=0; HI (resp. LO) <= `reg1_i` at the rising edge ending that cycle, only when `stall_req_o`=0.
- mult/multu: `wreg_o`=0, `wdata_o`=0. FSM:
  - IDLE: mult code present -> latch |reg1|,|reg2| (signed) or raw values (unsigned) and result sign = reg1[31]^reg2[31] (mult only); `stall_req_o`=1 combinationally; next BUSY, counter=0.
  - BUSY: per cycle, if multiplier LSB=1, acc += multiplicand; multiplicand <<1 (64-bit), multiplier >>1; counter++; `stall_req_o`=1; counter==31 -> DONE.
  - DONE: `stall_req_o`=0; {HI,LO} <= sign ? -acc : acc at the ending edge; next IDLE. Mult code still on inputs is not restarted.
- Magnitude of 0x80000000 is 2^31, representable in the 32-bit unsigned multiplier register.

## Timing
- Non-multiply ops: zero-latency combinational outputs; HI/LO writes visible to an mfhi/mflo in the next cycle.
- mult/multu occupy EX for 34 cycles: 1 IDLE-detect + 32 BUSY + 1 DONE; `stall_req_o` high for exactly 33 of them.
- Instruction following a mult reaches EX after the DONE edge and reads the new HI/LO.
- Reset (any time, including mid-multiply): state IDLE, counter 0, acc/operand registers 0, HI=LO=0; while `rst`=1 `wdata_o`=0, `wd_o`=0, `wreg_o`=0, `stall_req_o`=0. An aborted multiply leaves HI/LO at 0.
- mthi/mtlo never coincide with DONE (pipeline is stalled behind mult), so no write priority rule is needed; DONE takes priority if forced.

## Structure
- Shared package: aluop constants, FSM state enum (IDLE, BUSY, DONE).
- One sub-module `mul_iter`: shift-add engine (start, signed flag, operands in; busy, done, 64-bit product out). `ex_hilo` holds HI/LO, op mux and stall logic.

## Test plan
- or 0x25, reg1=0x0000FF00, reg2=0x00FF00FF, wreg_i=1, wd_i=3 -> `wdata_o`=0x00FFFFFF, `wreg_o`=1, `wd_o`=3.
- sra 0x03, reg1=4, reg2=0x80000000 -> 0xF8000000; srl same operands -> 0x08000000.
- movn with reg2=0 -> `wreg_o`=0; reg2=5, reg1=0x1234 -> `wreg_o`=1, `wdata_o`=0x1234; movz mirrors.
- mult 0x80000000 x 0x80000000 -> stall 33 cycles, then mfhi=0x40000000, mflo=0; mult 0xFFFFFFFF x 1 -> HI=LO=0xFFFFFFFF; multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- mthi 0xAAAA5555 then mfhi next cycle -> `wdata_o`=0xAAAA5555.
- Assert `rst` at BUSY cycle 10 -> `stall_req_o` drops immediately, HI=LO=0, next mult runs a full 34 cycles.
